// File: rtl/match_out_pkg.sv
// match_out_pkg: shared entry layout for the matched-pair output stage.
// The structs document the default-width layout; the top packs the same
// field order into a flat vector so other COOR_W/Z_W settings use it too.
package match_out_pkg;

    localparam int COOR_W_DEF = 10;
    localparam int Z_W_DEF    = 16;
    localparam int FLAG_W     = 3;

    typedef struct packed {
        logic [COOR_W_DEF-1:0] src_x;
        logic [COOR_W_DEF-1:0] src_y;
        logic [Z_W_DEF-1:0]    src_z;
        logic [COOR_W_DEF-1:0] dst_x;
        logic [COOR_W_DEF-1:0] dst_y;
        logic [Z_W_DEF-1:0]    dst_z;
    } pair_payload_t;

    typedef struct packed {
        logic          sof;
        logic          eof;
        logic          pair;
        pair_payload_t payload;
    } entry_t;

    // Width of one packed entry: flags plus the six payload fields.
    function automatic int entry_width(input int coor_w, input int z_w);
        return FLAG_W + 4 * coor_w + 2 * z_w;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: register-array first-word-fall-through FIFO.
// The head is held in its own register so that, once drained, the output
// keeps showing the last entry rather than a stale slot of the array.
module sync_fifo_fwft #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]     count_reg, count_next, remaining;
    logic [DATA_W-1:0] head_reg, head_next;
    logic              do_push, do_pop;

    // Pop only a present entry; a push into a full array is refused.
    always_comb begin
        do_pop      = pop && (count_reg != '0);
        do_push     = push && (count_reg != FULL_C);
        rd_ptr_next = rd_ptr_reg + AW'(do_pop);
        remaining   = count_reg - CW'(do_pop);
        count_next  = remaining + CW'(do_push);
        head_next   = head_reg;
        if (count_next != '0) begin
            // An entry landing in an otherwise empty FIFO is its own head.
            if (remaining == '0) head_next = din;
            else                 head_next = mem[rd_ptr_next];
        end
    end

    // Storage array, written at the write pointer; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

    // Pointers, occupancy and head register; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(do_push);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
        end
    end

    assign dout  = head_reg;
    assign valid = (count_reg != '0);
    assign count = count_reg;

endmodule

// File: rtl/match_pair_out_fifo.sv
// match_pair_out_fifo: elastic valid/ready output stage for matched pairs
// and frame markers. Pairs are dropped when fewer than two slots are free
// so that one slot stays reserved for a marker; markers are lost only when
// the FIFO is completely full, which raises a sticky error.
// Optional macro MATCH_OUT_DROP_CNT_EN builds the saturating drop counter.
module match_pair_out_fifo
    import match_out_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int COOR_W     = 10,
    parameter int Z_W        = 16,
    parameter int CNT_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_frame_start,
    input  logic              i_frame_end,
    input  logic              i_valid,
    input  logic [COOR_W-1:0] i_src_coor_x,
    input  logic [COOR_W-1:0] i_src_coor_y,
    input  logic [COOR_W-1:0] i_dst_coor_x,
    input  logic [COOR_W-1:0] i_dst_coor_y,
    input  logic [Z_W-1:0]    i_src_depth,
    input  logic [Z_W-1:0]    i_dst_depth,
    input  logic              i_ready,
    output logic              o_valid,
    output logic              o_sof,
    output logic              o_eof,
    output logic              o_pair,
    output logic [COOR_W-1:0] o_src_coor_x,
    output logic [COOR_W-1:0] o_src_coor_y,
    output logic [COOR_W-1:0] o_dst_coor_x,
    output logic [COOR_W-1:0] o_dst_coor_y,
    output logic [Z_W-1:0]    o_src_depth,
    output logic [Z_W-1:0]    o_dst_depth,
    output logic [CNT_W-1:0]  o_frame_pairs,
    output logic              o_drop,
    output logic              o_marker_err,
    output logic [CNT_W-1:0]  o_drop_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = entry_width(COOR_W, Z_W);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [CW-1:0]    count, free;
    logic [EW-1:0]    din, dout;
    logic             any_marker, pair_ok, drop_now, marker_room, marker_lost, push;
    logic             drop_reg, marker_err_reg;
    logic [CNT_W-1:0] frame_pairs_reg;

    // Admission decided from the occupancy before this cycle's pop.
    always_comb begin
        free        = DEPTH_C - count;
        any_marker  = i_frame_start || i_frame_end;
        pair_ok     = i_valid && (free >= CW'(2));
        drop_now    = i_valid && !pair_ok;
        marker_room = (free != '0);
        marker_lost = any_marker && !marker_room;
        push        = pair_ok || (any_marker && marker_room);
    end

    assign din = {i_frame_start, i_frame_end, pair_ok,
                  i_src_coor_x, i_src_coor_y, i_src_depth,
                  i_dst_coor_x, i_dst_coor_y, i_dst_depth};

    sync_fifo_fwft #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (EW)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push),
        .din   (din),
        .pop   (i_ready),
        .dout  (dout),
        .valid (o_valid),
        .count (count)
    );

    assign {o_sof, o_eof, o_pair,
            o_src_coor_x, o_src_coor_y, o_src_depth,
            o_dst_coor_x, o_dst_coor_y, o_dst_depth} = dout;

    // Drop pulse, sticky marker-loss flag and per-frame accepted-pair count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            drop_reg        <= 1'b0;
            marker_err_reg  <= 1'b0;
            frame_pairs_reg <= '0;
        end else begin
            drop_reg <= drop_now;
            if (marker_lost) marker_err_reg <= 1'b1;
            if (i_frame_start)
                frame_pairs_reg <= pair_ok ? CNT_W'(1) : '0;
            else if (pair_ok && (frame_pairs_reg != '1))
                frame_pairs_reg <= frame_pairs_reg + 1'b1;
        end
    end

    assign o_drop        = drop_reg;
    assign o_marker_err  = marker_err_reg;
    assign o_frame_pairs = frame_pairs_reg;

`ifdef MATCH_OUT_DROP_CNT_EN
    logic [CNT_W-1:0] drop_cnt_reg;

    // Saturating count of dropped pairs, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            drop_cnt_reg <= '0;
        else if (drop_now && (drop_cnt_reg != '1))
            drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end

    assign o_drop_cnt = drop_cnt_reg;
`else
    assign o_drop_cnt = '0;
`endif

endmodule
